// File: rtl/arb_pkg.sv
// Shared types and the address-window decoder for the fetch/data memory arbiter.
// Both requesters decode through the same function so the legality rules cannot drift apart.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ERR
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    typedef struct packed {
        logic        legal;
        logic [31:0] phys;
    } decode_t;

    // An address below base wraps to a huge offset and therefore fails the bound check.
    function automatic decode_t decode(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] words,
                                       input logic [31:0] phys_base);
        decode_t     res;
        logic [31:0] off;
        off       = (addr - base) >> 2;
        res.legal = (addr[1:0] == 2'b00) && (off < words);
        res.phys  = phys_base + off;
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports and memory-side port of the arbiter, bundled as one interface.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_AW     = 11
);
    logic                    i_req;
    logic [31:0]             i_addr;
    logic                    i_gnt;
    logic                    i_rvalid;
    logic [DATA_WIDTH-1:0]   i_rdata;
    logic                    i_err;

    logic                    d_req;
    logic                    d_we;
    logic [DATA_WIDTH/8-1:0] d_be;
    logic [31:0]             d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic                    d_gnt;
    logic                    d_rvalid;
    logic                    d_err;
    logic [DATA_WIDTH-1:0]   d_rdata;

    logic                    m_en;
    logic                    m_we;
    logic [DATA_WIDTH/8-1:0] m_be;
    logic [MEM_AW-1:0]       m_addr;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH-1:0]   m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_err, d_rdata,
        output m_en, m_we, m_be, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_err, d_rdata,
        input  m_en, m_we, m_be, m_addr, m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of arbitrations fetch has lost; sat tells the arbiter to let fetch win.
module arb_starve_cnt #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    assign sat = (cnt_q == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and data accesses.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT losses.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter logic [31:0] INS_BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] DATA_BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned INS_WORDS      = 1024,
    parameter int unsigned DATA_WORDS     = 1024,
    parameter int unsigned MEM_AW         = 11,
    parameter int unsigned MEM_LATENCY    = 1,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned LAT_W = $clog2(MEM_LATENCY) + 1;

    arb_state_t            state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  m_en_q, m_en_d;
    logic                  m_we_q, m_we_d;
    logic [BE_W-1:0]       m_be_q, m_be_d;
    logic [MEM_AW-1:0]     m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    decode_t dec_i, dec_d;
    logic    starve_sat;
    logic    grant_i, grant_d;
    logic    unused_phys_hi;

    assign dec_i = decode(bus.i_addr, INS_BASE_ADDR, 32'(INS_WORDS), 32'd0);
    assign dec_d = decode(bus.d_addr, DATA_BASE_ADDR, 32'(DATA_WORDS), 32'(INS_WORDS));
    assign unused_phys_hi = ^{dec_i.phys[31:MEM_AW], dec_d.phys[31:MEM_AW]};

    assign grant_i = (state_q == IDLE) && bus.i_req && (!bus.d_req || starve_sat);
    assign grant_d = (state_q == IDLE) && bus.d_req && !grant_i;

    arb_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (grant_d && bus.i_req),
        .clr  (grant_i),
        .sat  (starve_sat)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_d        = lat_q;
        m_en_d       = 1'b0;
        m_we_d       = 1'b0;
        m_be_d       = '0;
        m_addr_d     = m_addr_q;
        m_wdata_d    = '0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        bus.i_gnt    = 1'b0;
        bus.d_gnt    = 1'b0;
        bus.i_rvalid = 1'b0;
        bus.d_rvalid = 1'b0;
        bus.i_err    = 1'b0;
        bus.d_err    = 1'b0;
        bus.i_rdata  = i_rdata_q;
        bus.d_rdata  = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    bus.i_gnt = 1'b1;
                    owner_d   = OWN_I;
                    if (dec_i.legal) begin
                        state_d  = ISSUE;
                        m_en_d   = 1'b1;
                        m_be_d   = '1;
                        m_addr_d = dec_i.phys[MEM_AW-1:0];
                    end else begin
                        state_d = ERR;
                    end
                end else if (grant_d) begin
                    bus.d_gnt = 1'b1;
                    owner_d   = OWN_D;
                    if (dec_d.legal) begin
                        state_d   = ISSUE;
                        m_en_d    = 1'b1;
                        m_we_d    = bus.d_we;
                        m_be_d    = bus.d_be;
                        m_addr_d  = dec_d.phys[MEM_AW-1:0];
                        m_wdata_d = bus.d_we ? bus.d_wdata : '0;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ISSUE: begin
                lat_d   = '0;
                state_d = m_we_q ? IDLE : WAIT;
            end
            WAIT: begin
                // Terminal cycle is the one in which the memory's read data is valid.
                if (lat_q == LAT_W'(MEM_LATENCY - 1)) begin
                    state_d = IDLE;
                    if (owner_q == OWN_I) begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = bus.m_rdata;
                        i_rdata_d    = bus.m_rdata;
                    end else begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = bus.m_rdata;
                        d_rdata_d    = bus.m_rdata;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ERR: begin
                state_d = IDLE;
                if (owner_q == OWN_I) begin
                    bus.i_rvalid = 1'b1;
                    bus.i_err    = 1'b1;
                    bus.i_rdata  = '0;
                    i_rdata_d    = '0;
                end else begin
                    bus.d_rvalid = 1'b1;
                    bus.d_err    = 1'b1;
                    bus.d_rdata  = '0;
                    d_rdata_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            lat_q     <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_q     <= lat_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_be    = m_be_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LATENCY=2, one at MEM_LATENCY=1,
// each backed by a small fixed-content read pipeline modelling the memory macro.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(32), .MEM_AW(11)) bus_a ();
    mem_arbiter_if #(.DATA_WIDTH(32), .MEM_AW(11)) bus_b ();

    mem_arbiter #(
        .MEM_LATENCY(2)
    ) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    mem_arbiter #(
        .MEM_LATENCY(1)
    ) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    function automatic logic [31:0] mem_val(input logic [10:0] a);
        return (a == 11'd4) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(a));
    endfunction

    logic [31:0] pipe_a [2];
    logic [31:0] pipe_b;

    always @(posedge clk) begin
        pipe_a[0] <= (bus_a.m_en && !bus_a.m_we) ? mem_val(bus_a.m_addr) : 32'hBAD0_BAD0;
        pipe_a[1] <= pipe_a[0];
        pipe_b    <= (bus_b.m_en && !bus_b.m_we) ? mem_val(bus_b.m_addr) : 32'hBAD0_BAD0;
    end

    assign bus_a.m_rdata = pipe_a[1];
    assign bus_b.m_rdata = pipe_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_a.i_req = 0; bus_a.i_addr = 0; bus_a.d_req = 0; bus_a.d_we = 0;
        bus_a.d_be = 0; bus_a.d_addr = 0; bus_a.d_wdata = 0;
        bus_b.i_req = 0; bus_b.i_addr = 0; bus_b.d_req = 0; bus_b.d_we = 0;
        bus_b.d_be = 0; bus_b.d_addr = 0; bus_b.d_wdata = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        clear_inputs();

        // Reset state
        cyc(); cyc(); #2;
        check("rst_i_gnt", bus_a.i_gnt, 0);
        check("rst_d_gnt", bus_a.d_gnt, 0);
        check("rst_rvalid", {bus_a.i_rvalid, bus_a.d_rvalid, bus_a.i_err, bus_a.d_err}, 0);
        check("rst_m_en", {bus_a.m_en, bus_a.m_we}, 0);
        check("rst_m_addr", bus_a.m_addr, 0);
        check("rst_m_be", bus_a.m_be, 0);
        check("rst_m_wdata", bus_a.m_wdata, 0);
        check("rst_i_rdata", bus_a.i_rdata, 0);
        check("rst_d_rdata", bus_a.d_rdata, 0);
        cyc(); reset = 1'b0; #2;

        // Single fetch at 0x10, latency 2
        cyc(); bus_a.i_req = 1; bus_a.i_addr = 32'h10; #2;
        check("rd_i_gnt", bus_a.i_gnt, 1);
        cyc(); bus_a.i_req = 0; #2;
        check("rd_m_en", bus_a.m_en, 1);
        check("rd_m_addr", bus_a.m_addr, 4);
        check("rd_m_we", bus_a.m_we, 0);
        check("rd_m_be", bus_a.m_be, 4'hF);
        check("rd_early_rvalid", bus_a.i_rvalid, 0);
        cyc(); #2;
        check("rd_wait_rvalid", bus_a.i_rvalid, 0);
        check("rd_wait_m_en", bus_a.m_en, 0);
        cyc(); #2;
        check("rd_rvalid", bus_a.i_rvalid, 1);
        check("rd_rdata", bus_a.i_rdata, 32'hDEAD_BEEF);
        check("rd_err", bus_a.i_err, 0);
        cyc(); #2;
        check("rd_rvalid_drop", bus_a.i_rvalid, 0);
        check("rd_rdata_hold", bus_a.i_rdata, 32'hDEAD_BEEF);

        // Data write at 0x80000008
        cyc();
        bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_be = 4'b0011;
        bus_a.d_addr = 32'h8000_0008; bus_a.d_wdata = 32'h1234; #2;
        check("wr_d_gnt", bus_a.d_gnt, 1);
        cyc(); bus_a.d_req = 0; bus_a.d_we = 0; bus_a.d_be = 0; bus_a.d_wdata = 0; #2;
        check("wr_m_en", bus_a.m_en, 1);
        check("wr_m_we", bus_a.m_we, 1);
        check("wr_m_addr", bus_a.m_addr, 1026);
        check("wr_m_be", bus_a.m_be, 4'b0011);
        check("wr_m_wdata", bus_a.m_wdata, 32'h1234);
        check("wr_no_rvalid", bus_a.d_rvalid, 0);
        cyc(); #2;
        check("wr_no_rvalid2", bus_a.d_rvalid, 0);
        check("wr_m_en_off", {bus_a.m_en, bus_a.m_we}, 0);
        check("wr_m_addr_hold", bus_a.m_addr, 1026);

        // Illegal data read past the window
        cyc(); bus_a.d_req = 1; bus_a.d_addr = 32'h8000_1000; bus_a.d_be = 4'hF; #2;
        check("ild_gnt", bus_a.d_gnt, 1);
        cyc(); bus_a.d_req = 0; #2;
        check("ild_rvalid", bus_a.d_rvalid, 1);
        check("ild_err", bus_a.d_err, 1);
        check("ild_rdata", bus_a.d_rdata, 0);
        check("ild_m_en", bus_a.m_en, 0);
        cyc(); #2;
        check("ild_done", {bus_a.d_rvalid, bus_a.d_err, bus_a.m_en}, 0);

        // Illegal data read below the window base
        cyc(); bus_a.d_req = 1; bus_a.d_addr = 32'h7FFF_FFFC; #2;
        check("ilb_gnt", bus_a.d_gnt, 1);
        cyc(); bus_a.d_req = 0; #2;
        check("ilb_err", {bus_a.d_rvalid, bus_a.d_err, bus_a.m_en}, 3'b110);

        // Misaligned fetch
        cyc(); bus_a.i_req = 1; bus_a.i_addr = 32'h2; #2;
        check("ili_gnt", bus_a.i_gnt, 1);
        cyc(); bus_a.i_req = 0; #2;
        check("ili_rvalid", bus_a.i_rvalid, 1);
        check("ili_err", bus_a.i_err, 1);
        check("ili_rdata", bus_a.i_rdata, 0);
        check("ili_m_en", bus_a.m_en, 0);
        cyc(); #2;

        // Both requesters held: four data grants, then one fetch grant, repeating
        cyc();
        bus_a.i_req = 1; bus_a.i_addr = 32'h20;
        bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_be = 4'hF; bus_a.d_addr = 32'h8000_0000;
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            #2;
            if (bus_a.i_gnt || bus_a.d_gnt) begin
                check($sformatf("starve_gnt%0d_is_fetch", n), 32'(bus_a.i_gnt),
                      ((n % 5) == 4) ? 32'd1 : 32'd0);
                n++;
            end
            cyc();
        end
        check("starve_grant_count", n, 10);
        clear_inputs();
        repeat (6) cyc();

        // Reset while a fetch read sits in WAIT
        bus_a.i_req = 1; bus_a.i_addr = 32'h10; #2;
        check("rw_gnt", bus_a.i_gnt, 1);
        cyc(); bus_a.i_req = 0;
        cyc(); reset = 1'b1; #2;
        check("rw_wait_rvalid", bus_a.i_rvalid, 0);
        cyc(); reset = 1'b0; #2;
        check("rw_rvalid", bus_a.i_rvalid, 0);
        check("rw_i_rdata", bus_a.i_rdata, 0);
        check("rw_m_en", bus_a.m_en, 0);
        check("rw_m_addr", bus_a.m_addr, 0);
        check("rw_m_be", bus_a.m_be, 0);
        check("rw_d_rdata", bus_a.d_rdata, 0);
        for (int c = 0; c < 3; c++) begin
            cyc(); #2;
            check($sformatf("rw_quiet%0d", c), {bus_a.i_rvalid, bus_a.d_rvalid}, 0);
        end
        cyc(); bus_a.d_req = 1; bus_a.d_addr = 32'h8000_0004; bus_a.d_be = 4'hF; #2;
        check("rw_new_gnt", bus_a.d_gnt, 1);
        cyc(); bus_a.d_req = 0; #2;
        check("rw_new_m_addr", bus_a.m_addr, 1025);
        cyc(); cyc(); #2;
        check("rw_new_rvalid", bus_a.d_rvalid, 1);
        check("rw_new_rdata", bus_a.d_rdata, mem_val(11'd1025));

        // Back-to-back data reads at latency 1: grants every 3 cycles, rdata held between
        cyc();
        bus_b.d_req = 1; bus_b.d_we = 0; bus_b.d_be = 4'hF; bus_b.d_addr = 32'h8000_0010;
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("b2b_gnt%0d", k), bus_b.d_gnt, 1);
            if (k > 0) begin
                check($sformatf("b2b_hold%0d", k), bus_b.d_rdata, mem_val(11'(1027 + k)));
            end
            cyc(); bus_b.d_addr = 32'h8000_0010 + 32'(4 * (k + 1)); #2;
            check($sformatf("b2b_issue%0d", k), {bus_b.d_gnt, bus_b.m_en, bus_b.d_rvalid},
                  3'b010);
            check($sformatf("b2b_m_addr%0d", k), bus_b.m_addr, 32'(1028 + k));
            cyc(); #2;
            check($sformatf("b2b_resp%0d", k), {bus_b.d_gnt, bus_b.d_rvalid}, 2'b01);
            check($sformatf("b2b_rdata%0d", k), bus_b.d_rdata, mem_val(11'(1028 + k)));
            cyc();
        end
        bus_b.d_req = 0;
        #2;
        check("b2b_final_hold", bus_b.d_rdata, mem_val(11'd1030));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the core's instruction-fetch port and data port onto one shared single-port word memory. It sits between `riscv_core` and the unified memory macro. It decodes both address windows into one physical word index and sequences each access through a fixed-latency request/response protocol. Data accesses have priority, and a starvation counter bounds fetch delay.

## Interface
Parameters:
- `INS_BASE_ADDR`, 32'h0, byte base of the fetch window
- `DATA_BASE_ADDR`, 32'h80000000, byte base of the data window
- `DATA_WIDTH`, 32, word width
- `INS_WORDS`, 1024, words in the fetch window; these map to physical words 0..INS_WORDS-1
- `DATA_WORDS`, 1024, words in the data window; these map to physical words INS_WORDS..INS_WORDS+DATA_WORDS-1
- `MEM_AW`, 11, physical word-address width; must satisfy 2**MEM_AW >= INS_WORDS+DATA_WORDS
- `MEM_LATENCY`, 1, cycles from the `m_en` cycle to valid `m_rdata`; must be >= 1
- `STARVE_LIMIT`, 4, number of lost arbitrations after which fetch wins

Ports:
- `clk`, in, 1, single clock; all logic is on the rising edge
- `reset`, in, 1, synchronous, active-high
- `i_req`, in, 1, fetch request; held until `i_gnt`
- `i_addr`, in, 32, fetch byte address
- `i_gnt`, out, 1, one-cycle accept pulse
- `i_rvalid`, out, 1, one-cycle response pulse
- `i_rdata`, out, DATA_WIDTH, fetch data; held stable between pulses
- `i_err`, out, 1, valid with `i_rvalid`
- `d_req`, `d_we`, in, 1 each, data request and write select
- `d_be`, in, DATA_WIDTH/8, byte enables
- `d_addr`, `d_wdata`, in, 32/DATA_WIDTH, data address and write data
- `d_gnt`, `d_rvalid`, `d_err`, out, 1 each
- `d_rdata`, out, DATA_WIDTH
- `m_en`, `m_we`, out, 1 each, memory strobe and write select
- `m_be`, out, DATA_WIDTH/8, memory byte enables
- `m_addr`, out, MEM_AW, physical word index
- `m_wdata`, out, DATA_WIDTH, memory write data
- `m_rdata`, in, DATA_WIDTH, memory read data

## Operation
- FSM states:
  - IDLE: arbitrate. A decoded-legal winner goes to ISSUE. An illegal winner goes to ERR.
  - ISSUE: drive `m_en` for exactly 1 cycle. A write returns to IDLE. A read goes to WAIT.
  - WAIT: count MEM_LATENCY-1 cycles. On the terminal cycle, `m_rdata` is valid. Pulse the owner's `rvalid`, capture into its `rdata` hold register, then go to IDLE.
  - ERR: pulse the owner's `rvalid` and `err` for 1 cycle with `rdata`=0, then go to IDLE.
- MEM_LATENCY=1 means the WAIT terminal cycle is its first cycle.
- Arbitration happens in IDLE only. `gnt` is combinational in the arbitration cycle.
- The request fields are latched into internal registers at `gnt`. Requesters may change them afterwards.
- Priority:
  - Data beats fetch, except when `starve_cnt` == STARVE_LIMIT; then fetch wins.
  - `starve_cnt` increments, saturating, on each IDLE cycle where `i_req` and `d_gnt` are both set.
  - `starve_cnt` clears on `i_gnt`.
- Decode:
  - Fetch is legal if `i_addr`[1:0]==0 and (`i_addr`-INS_BASE_ADDR)>>2 < INS_WORDS. Then `m_addr` = that offset, `m_be` = all ones, `m_we` = 0.
  - Data is legal if `d_addr`[1:0]==0 and (`d_addr`-DATA_BASE_ADDR)>>2 < DATA_WORDS. Then `m_addr` = INS_WORDS + offset, `m_be` = `d_be`, `m_we` = `d_we`.
  - Subtraction is 32-bit unsigned. An address below base wraps large and is illegal.
- Writes produce no `rvalid`. A write error produces a `d_rvalid`+`d_err` pulse with no memory access.
- A request arriving in a non-IDLE state waits. Both requesters waiting on return to IDLE is the simultaneous case and follows the priority rule.

## Timing
- Reset outputs:
  - All `gnt`, `rvalid`, `err`, `m_en`, `m_we` = 0.
  - All `rdata`, `m_addr`, `m_be`, `m_wdata` = 0.
  - FSM = IDLE, `starve_cnt` = 0.
- Reset mid-operation drops any in-flight response. No `rvalid` fires after reset.
- Read: `gnt` at cycle T, `m_en` at T+1, `rvalid` at T+1+MEM_LATENCY. The next grant is no earlier than T+2+MEM_LATENCY.
- Write: `gnt` at T, `m_en`+`m_we` at T+1. The next grant is no earlier than T+2.
- Error: `gnt` at T, `rvalid`+`err` at T+1. The next grant is no earlier than T+2.
- `m_*` outputs are registered. They are zero outside ISSUE, except that `m_addr` holds its value.

## Structure
- `arb_pkg` contains:
  - the `arb_state_t` enum (IDLE, ISSUE, WAIT, ERR)
  - the `owner_t` enum (OWN_I, OWN_D)
  - the `decode_t` struct (legal, phys addr)
- Sub-module `arb_starve_cnt`: the saturating counter with clear; width $clog2(STARVE_LIMIT+1).
- Decode stays as two instances of a package function.

## Test plan
- Single fetch at `i_addr`=0x10, MEM_LATENCY=2, memory word 4 = 0xDEADBEEF -> `i_gnt` T, `m_addr`=4 at T+1, `i_rvalid`+`i_rdata`=0xDEADBEEF at T+3.
- Data write at 0x80000008, `d_be`=4'b0011, `d_wdata`=0x1234 -> `m_addr`=INS_WORDS+2, `m_be`=0011, `m_we`=1 at T+1, no `d_rvalid`.
- `i_req` and `d_req` held continuously with reads and STARVE_LIMIT=4 -> four data grants, then one fetch grant, and the pattern repeats.
- Illegal accesses:
  - `d_addr`=0x80001000 (past DATA_WORDS): `d_rvalid`+`d_err` at T+1, `d_rdata`=0, `m_en` never set.
  - `i_addr`=0x2: `i_err`.
- Reset asserted in WAIT -> no `rvalid`, all outputs 0 next cycle, and a new request is granted from IDLE after reset.
- Back-to-back data reads, MEM_LATENCY=1 -> grants spaced exactly 3 cycles; `d_rdata` holds between pulses.
